// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter onto one req/gnt/rvalid memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin conflict resolution; otherwise data has fixed priority.
module mem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        protocol_err_o
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

    logic [CNT_W-1:0]           count_q, count_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [MAX_OUTSTANDING-1:0] id_q, id_d;
    logic                       lock_q, lock_d, lock_sel_q, lock_sel_d;
    logic                       perr_q, perr_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic                       last_q, last_d;
`endif

    logic sel, handshake, pop, empty, head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        empty     = (count_q == '0);
        mem_req_o = (instr_req_i || data_req_i) && (count_q < CNT_MAX);

        // A stalled requester keeps the port until it withdraws its request.
        if (lock_q && ((lock_sel_q == SEL_D) ? data_req_i : instr_req_i)) begin
            sel = lock_sel_q;
        end else if (instr_req_i && data_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            sel = (last_q == SEL_D) ? SEL_I : SEL_D;
`else
            sel = SEL_D;
`endif
        end else begin
            sel = data_req_i ? SEL_D : SEL_I;
        end

        mem_addr_o  = (sel == SEL_D) ? data_addr_i  : instr_addr_i;
        mem_we_o    = (sel == SEL_D) ? data_we_i    : 1'b0;
        mem_be_o    = (sel == SEL_D) ? data_be_i    : 4'hF;
        mem_wdata_o = (sel == SEL_D) ? data_wdata_i : 32'h0;

        handshake   = mem_req_o && mem_gnt_i;
        instr_gnt_o = handshake && (sel == SEL_I);
        data_gnt_o  = handshake && (sel == SEL_D);

        // Responses with nothing outstanding are dropped and flagged.
        pop            = mem_rvalid_i && !empty;
        head           = id_q[rd_ptr_q];
        instr_rvalid_o = pop && (head == SEL_I);
        data_rvalid_o  = pop && (head == SEL_D);

        id_d     = id_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (handshake) begin
            id_d[wr_ptr_q] = sel;
            wr_ptr_d       = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (handshake && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !handshake) begin
            count_d = count_q - CNT_W'(1);
        end

        lock_d     = mem_req_o && !mem_gnt_i;
        lock_sel_d = sel;
        perr_d     = perr_q || (mem_rvalid_i && empty);
`ifdef ARB_ROUND_ROBIN_EN
        last_d = handshake ? sel : last_q;
`endif
    end

    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign protocol_err_o = perr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            id_q       <= '0;
            lock_q     <= 1'b0;
            lock_sel_q <= SEL_D;
            perr_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= SEL_D;
`endif
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            id_q       <= id_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            perr_q     <= perr_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a queue-based reference model.
module tb_mem_port_arbiter;
    localparam int MAXO = 2;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        ir, dr, dwe, mg, mrv;
    logic [31:0] ia, da, dwd, mrd;
    logic [3:0]  dbe;
    logic        instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
    logic [31:0] instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;
    logic        mem_req_o, mem_we_o, protocol_err_o;
    logic [3:0]  mem_be_o;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit q[$];
    bit m_lock, m_lsel, m_last, m_perr;

    mem_port_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clock(clock), .reset(reset),
        .instr_req_i(ir), .instr_addr_i(ia), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(dr), .data_we_i(dwe), .data_be_i(dbe), .data_addr_i(da),
        .data_wdata_i(dwd), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mg),
        .mem_rvalid_i(mrv), .mem_rdata_i(mrd), .protocol_err_o(protocol_err_o)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_sel();
        if (m_lock && (m_lsel ? dr : ir)) return m_lsel;
        if (ir && dr) return RR ? !m_last : 1'b1;
        return dr;
    endfunction

    // One clock: compare every output against the model, then advance the model.
    task automatic tick();
        int  n;
        bit  e_req, s, hs, pp;
        #2;
        n     = q.size();
        e_req = (ir || dr) && (n < MAXO);
        s     = model_sel();
        hs    = e_req && mg;
        pp    = mrv && (n > 0);
        chk("m_req", mem_req_o, e_req);
        chk("m_igt", instr_gnt_o, hs && !s);
        chk("m_dgt", data_gnt_o, hs && s);
        chk("m_irv", instr_rvalid_o, pp && (q[0] == 1'b0));
        chk("m_drv", data_rvalid_o, pp && (q[0] == 1'b1));
        if (e_req) begin
            chk("m_addr", mem_addr_o, s ? da : ia);
            chk("m_we", mem_we_o, s ? dwe : 1'b0);
            chk("m_be", mem_be_o, s ? dbe : 4'hF);
            chk("m_wd", mem_wdata_o, s ? dwd : 32'h0);
        end
        chk("m_ird", instr_rdata_o, mrd);
        chk("m_drd", data_rdata_o, mrd);
        chk("m_perr", protocol_err_o, m_perr);
        @(posedge clock);
        if (pp) void'(q.pop_front());
        if (hs) begin
            q.push_back(s);
            m_last = s;
        end
        m_lock = e_req && !mg;
        m_lsel = s;
        if (mrv && n == 0) m_perr = 1'b1;
        #1;
    endtask

    task automatic idle_inputs();
        ir = 0; dr = 0; dwe = 0; mg = 0; mrv = 0;
        ia = 0; da = 0; dwd = 0; mrd = 0; dbe = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        chk("rst_perr", protocol_err_o, 1'b0);
        chk("rst_req", mem_req_o, 1'b0);
        chk("rst_gnt", {instr_gnt_o, data_gnt_o}, 2'b00);
        chk("rst_rv", {instr_rvalid_o, data_rvalid_o}, 2'b00);
        @(posedge clock);
        #1;
        reset = 1'b0;
        q.delete();
        m_lock = 0; m_lsel = 1; m_last = 1; m_perr = 0;
    endtask

    initial begin
        do_reset();

        // Single instruction fetch with response two cycles later
        ir = 1; ia = 32'h1A000080; mg = 1;
        #1;
        chk("t023_igt", instr_gnt_o, 1'b1);
        chk("t023_be", mem_be_o, 4'hF);
        chk("t023_we", mem_we_o, 1'b0);
        tick();
        ir = 0; mg = 0;
        tick();
        mrv = 1; mrd = 32'h00000013;
        #1;
        chk("t023_irv", instr_rvalid_o, 1'b1);
        chk("t023_drv", data_rvalid_o, 1'b0);
        chk("t023_rd", instr_rdata_o, 32'h13);
        tick();
        mrv = 0;

        // Both ports requesting continuously
        do_reset();
        ir = 1; dr = 1; ia = 32'h2000; da = 32'h3000; mg = 1;
        for (int k = 0; k < 4; k++) begin
            mrv = (k > 0);
            #1;
            chk("t024_igt", instr_gnt_o, RR && (k % 2 == 0));
            chk("t024_dgt", data_gnt_o, !(RR && (k % 2 == 0)));
            tick();
        end
        ir = 0; dr = 0; mrv = 1;
        tick();
        mrv = 0;

        // Stalled data store holds the port against a later instruction request
        do_reset();
        dr = 1; dwe = 1; da = 32'h100; dbe = 4'h3; dwd = 32'hCAFE0001; mg = 0;
        ia = 32'h4000;
        for (int k = 0; k < 3; k++) begin
            ir = (k > 0);
            #1;
            chk("t025_addr", mem_addr_o, 32'h100);
            chk("t025_be", mem_be_o, 4'h3);
            chk("t025_dgt", data_gnt_o, 1'b0);
            tick();
        end
        mg = 1;
        #1;
        chk("t025_dgt4", data_gnt_o, 1'b1);
        chk("t025_igt4", instr_gnt_o, 1'b0);
        tick();
        dr = 0;
        #1;
        chk("t025_igt5", instr_gnt_o, 1'b1);
        tick();
        ir = 0; mg = 0; mrv = 1;
        tick();
        tick();
        mrv = 0;

        // Outstanding limit: same-cycle response does not unblock the request
        ir = 1; mg = 1; ia = 32'h5000;
        tick();
        tick();
        mrv = 1;
        #1;
        chk("t026_full", mem_req_o, 1'b0);
        chk("t026_igt", instr_gnt_o, 1'b0);
        tick();
        mrv = 0;
        #1;
        chk("t026_req", mem_req_o, 1'b1);
        tick();
        ir = 0; mrv = 1;
        tick();
        tick();
        mrv = 0;

        // In-order response routing
        ir = 1; mg = 1;
        tick();
        ir = 0; dr = 1; dwe = 0; da = 32'h6000;
        tick();
        dr = 0; mg = 0; mrv = 1;
        #1;
        chk("t027_irv", instr_rvalid_o, 1'b1);
        chk("t027_drv0", data_rvalid_o, 1'b0);
        tick();
        #1;
        chk("t027_irv1", instr_rvalid_o, 1'b0);
        chk("t027_drv", data_rvalid_o, 1'b1);
        tick();
        mrv = 0;

        // Stray response sets the sticky error
        mrv = 1;
        #1;
        chk("t028_rv", {instr_rvalid_o, data_rvalid_o}, 2'b00);
        tick();
        mrv = 0;
        #1;
        chk("t028_err", protocol_err_o, 1'b1);
        tick();
        tick();
        chk("t028_hold", protocol_err_o, 1'b1);

        // Transaction outstanding at reset is discarded
        do_reset();
        ir = 1; mg = 1;
        tick();
        do_reset();
        mrv = 1;
        #1;
        chk("t020_rv", instr_rvalid_o, 1'b0);
        tick();
        mrv = 0;
        #1;
        chk("t020_err", protocol_err_o, 1'b1);
        tick();

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            ir  = 1'($urandom_range(0, 1));
            dr  = 1'($urandom_range(0, 1));
            dwe = 1'($urandom_range(0, 1));
            dbe = 4'($urandom_range(0, 15));
            ia  = $urandom();
            da  = $urandom();
            dwd = $urandom();
            mrd = $urandom();
            mg  = ($urandom_range(0, 3) != 0);
            if (q.size() > 0) mrv = 1'($urandom_range(0, 1));
            else              mrv = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
